// File: rtl/button_pkg.sv
// Shared constants and helpers for the pushbutton front end.
// Exports LED mode encodings and an ms-to-cycles conversion.
package button_pkg;

  localparam logic MODE_FOLLOW = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

  function automatic int unsigned ms_to_cycles(
    input int unsigned clk_hz,
    input int unsigned ms
  );
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-flop sync, debounce counter, edge + toggle regs.
// clk/rst in; sw raw level in; stable, press, rel, tog registered out.
module debounce_ch
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic stable,
  output logic press,
  output logic rel,
  output logic tog
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sw_meta;
  logic             sw_sync;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             accept;

  assign differ = (sw_sync != stable);
  // New level has held for the full window; take it this edge.
  assign accept = differ && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta <= 1'b0;
      sw_sync <= 1'b0;
      cnt     <= '0;
      stable  <= 1'b0;
      press   <= 1'b0;
      rel     <= 1'b0;
      tog     <= 1'b0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      press   <= accept & sw_sync;
      rel     <= accept & ~sw_sync;
      if (!differ) begin
        cnt <= '0;
      end else if (accept) begin
        cnt    <= '0;
        stable <= sw_sync;
        if (sw_sync) tog <= ~tog;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_leds.sv
// N-channel button front end: debounced level, press/release pulses,
// LED per channel. CLK/RST; SW, MODE in; STABLE, PRESS, RELEASE, LED out.
module button_leds
  import button_pkg::*;
#(
  parameter int N = 2,
  parameter int DEBOUNCE_CYCLES = ms_to_cycles(12_000_000, 20),
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] SW,
  input  logic [N-1:0] MODE,
  output logic [N-1:0] STABLE,
  output logic [N-1:0] PRESS,
  output logic [N-1:0] RELEASE,
  output logic [N-1:0] LED
);

  logic [N-1:0] tog;

  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk   (CLK),
      .rst   (RST),
      .sw    (SW[i]),
      .stable(STABLE[i]),
      .press (PRESS[i]),
      .rel   (RELEASE[i]),
      .tog   (tog[i])
    );

    // Mode only selects the view; tog keeps running underneath.
    assign LED[i] = (MODE[i] == MODE_TOGGLE)
                  ? tog[i] : STABLE[i];
  end

endmodule

// File: tb/tb_button_leds.sv
// Scoreboard bench for button_leds, N=2, DEBOUNCE_CYCLES=4.
// Expected pulse events queued by stimulus; monitor pops on each pulse.
module tb_button_leds;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] SW;
  logic [1:0] MODE;
  logic [1:0] STABLE;
  logic [1:0] PRESS;
  logic [1:0] RELEASE;
  logic [1:0] LED;

  button_leds #(
    .N(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .SW     (SW),
    .MODE   (MODE),
    .STABLE (STABLE),
    .PRESS  (PRESS),
    .RELEASE(RELEASE),
    .LED    (LED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic [1:0] pr;
    logic [1:0] rl;
    logic [1:0] led;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Latency from driving SW after edge e: sampled at e+1, seen at e+6.
  localparam int LAT = 6;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic expect_ev(
    input int off,
    input logic [1:0] st, pr, rl, led
  );
    exp_t e;
    e.cyc = cyc + off;
    e.st  = st;
    e.pr  = pr;
    e.rl  = rl;
    e.led = led;
    q.push_back(e);
  endtask

  task automatic chk(
    input string nm,
    input logic [7:0] act,
    input logic [7:0] req
  );
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (cyc %0d)",
               nm, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] outs();
    return {STABLE, PRESS, RELEASE, LED};
  endfunction

  // Monitor: fires on any pulse or when an expected event is due.
  initial forever begin
    @(negedge CLK);
    if ((PRESS | RELEASE) != 2'b00 ||
        (q.size() > 0 && q[0].cyc == cyc)) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got P=%b R=%b want none (cyc %0d)",
                 PRESS, RELEASE, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc != cyc || outs() !== {e.st, e.pr, e.rl, e.led}) begin
          n_fail++;
          $display("FAIL event: got cyc %0d S/P/R/L=%b want cyc %0d %b",
                   cyc, outs(), e.cyc, {e.st, e.pr, e.rl, e.led});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    RST  = 1'b1;
    SW   = 2'b11;
    MODE = 2'b00;

    // Reset with both buttons held, then re-accept as fresh press.
    tick(2);
    chk("reset_outs", outs(), 8'h00);
    MODE = 2'b11;
    #1;
    chk("reset_led_tog", {6'd0, LED}, 8'h00);
    MODE = 2'b00;
    RST  = 1'b0;
    expect_ev(LAT, 2'b11, 2'b11, 2'b00, 2'b11);
    tick(10);
    chk("held_after_reset", outs(), {2'b11, 2'b00, 2'b00, 2'b11});
    SW = 2'b00;
    expect_ev(LAT, 2'b00, 2'b00, 2'b11, 2'b00);
    tick(10);

    // Clean press/release on ch0 in follow mode.
    SW = 2'b01;
    expect_ev(LAT, 2'b01, 2'b01, 2'b00, 2'b01);
    tick(LAT - 1);
    chk("pre_accept", outs(), 8'h00);
    tick(3);
    chk("ch0_held", outs(), {2'b01, 2'b00, 2'b00, 2'b01});
    SW = 2'b00;
    expect_ev(LAT, 2'b00, 2'b00, 2'b01, 2'b00);
    tick(10);

    // Bounce: 3 high, 1 low, 3 high -> nothing accepted.
    SW = 2'b01;
    tick(3);
    SW = 2'b00;
    tick(1);
    SW = 2'b01;
    tick(3);
    SW = 2'b00;
    tick(3);
    chk("bounce_mid", outs(), 8'h00);
    tick(7);
    chk("bounce_end", outs(), 8'h00);

    // Toggle mode on ch0 (tog[0] is 0 here, tog[1] is 1).
    MODE = 2'b01;
    #1;
    chk("tog_start", {6'd0, LED}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      logic [1:0] l;
      l = (i % 2 == 0) ? 2'b01 : 2'b00;
      SW = 2'b01;
      expect_ev(LAT, 2'b01, 2'b01, 2'b00, l);
      tick(10);
      SW = 2'b00;
      expect_ev(LAT, 2'b00, 2'b00, 2'b01, l);
      tick(10);
      chk("tog_hold", {6'd0, LED}, {6'd0, l});
    end
    MODE = 2'b00;
    #1;
    chk("mode_follow", {6'd0, LED}, 8'h00);
    MODE = 2'b01;
    #1;
    chk("mode_back", {6'd0, LED}, 8'h01);
    MODE = 2'b00;

    // Same-cycle press, ch1 bounces once before holding.
    SW = 2'b11;
    expect_ev(LAT, 2'b01, 2'b01, 2'b00, 2'b01);
    expect_ev(LAT + 3, 2'b11, 2'b10, 2'b00, 2'b11);
    tick(2);
    SW = 2'b01;
    tick(1);
    SW = 2'b11;
    tick(12);
    SW = 2'b00;
    expect_ev(LAT, 2'b00, 2'b00, 2'b11, 2'b00);
    tick(10);

    // Reset at count 2 on ch1 discards the count.
    SW = 2'b10;
    tick(4);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    chk("midcount_reset", outs(), 8'h00);
    MODE = 2'b11;
    #1;
    chk("tog_cleared", {6'd0, LED}, 8'h00);
    MODE = 2'b00;
    expect_ev(LAT, 2'b10, 2'b10, 2'b00, 2'b10);
    tick(10);
    SW = 2'b00;
    expect_ev(LAT, 2'b00, 2'b00, 2'b10, 2'b00);
    tick(10);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missing_event: got none want cyc %0d", e.cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/button_leds.md
# button_leds

Parametrised N-channel pushbutton front end for the board tests: each raw button input is synchronised, debounced and edge-detected, then drives one LED either directly or as a press-to-toggle latch. It supersedes the direct button-to-LED wiring in the pushbutton test and gives later tests clean, single-cycle press/release events.

## Interface

Parameters:
- N, 2, number of button/LED channels (≥1)
- DEBOUNCE_CYCLES, 240000, cycles an input must hold a new level before it is accepted (20 ms at 12 MHz); ≥2; benches use 4
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width (derived, not overridden)

Ports:
- CLK  in  1  system clock; sole clock
- RST  in  1  synchronous reset, active-high
- SW  in  N  raw asynchronous button levels, 1 = pressed
- MODE  in  N  per-channel LED mode: 0 = follow, 1 = toggle; synchronous to CLK
- STABLE  out  N  debounced button level
- PRESS  out  N  one-cycle pulse on accepted 0→1 of STABLE
- RELEASE  out  N  one-cycle pulse on accepted 1→0 of STABLE
- LED  out  N  LED drive

## Operation

- Per channel, independent; no shared state between channels.
- Synchroniser: two flops, sw_meta <= SW, sw_sync <= sw_meta.
- Debouncer, per channel, counter cnt (CNT_W bits):
  - sw_sync == STABLE: cnt <= 0.
  - sw_sync != STABLE and cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sw_sync != STABLE and cnt == DEBOUNCE_CYCLES-1: STABLE <= sw_sync, cnt <= 0.
  - Any bounce back to STABLE level restarts the count from 0; no partial credit.
- Edge outputs, registered: PRESS <= (acceptance edge with sw_sync=1); RELEASE <= (acceptance edge with sw_sync=0); otherwise 0.
- Toggle latch tog: flips on each acceptance edge with sw_sync=1, regardless of MODE.
- LED: MODE=0 → LED = STABLE; MODE=1 → LED = tog. Combinational mux of registered values; changing MODE takes effect the same cycle and does not disturb tog.
- Counter never wraps: it is bounded by the compare at DEBOUNCE_CYCLES-1.

## Timing

- Reset: sw_meta, sw_sync, cnt, STABLE, PRESS, RELEASE, tog all 0; hence LED = 0 in both modes. Reset mid-count discards the count; a button held through reset is re-accepted as a fresh press (full latency) after RST deasserts.
- Latency: SW level sampled at edge k and held → STABLE, PRESS/RELEASE and tog update at edge k+1+DEBOUNCE_CYCLES.
- PRESS/RELEASE high for exactly one cycle per accepted edge; never both high on one channel; never high in consecutive cycles on one channel (minimum DEBOUNCE_CYCLES between accepted edges).
- Glitches shorter than DEBOUNCE_CYCLES cycles at sw_sync produce no output change.
- Simultaneous events on different channels are processed independently in the same cycle.
- RST dominates all other activity in the cycle it is sampled.

## Structure

- Package button_pkg: MODE_FOLLOW = 1'b0, MODE_TOGGLE = 1'b1 constants; debounce-cycle helper for ms-to-cycles at a given clock frequency.
- One sub-module, debounce_ch: single-channel synchroniser + counter + edge/toggle registers; top-level button_leds instantiates N copies with a generate loop and holds the LED mux.

## Test plan

Benches use N=2, DEBOUNCE_CYCLES=4.
- Reset: RST=1 two cycles with SW=2'b11 → all outputs 0; after release, STABLE=2'b11 and PRESS=2'b11 for one cycle at edge 5 after first sampling edge, LED=2'b11 (MODE=0).
- Clean press ch0, MODE=0: SW[0] 0→1 held → STABLE[0], LED[0] rise exactly 5 edges after sampling, PRESS[0] one cycle; release → RELEASE[0] one cycle after 5 edges, LED[0]=0.
- Bounce: SW[0] pulses high 3 cycles, low 1, high 3, low → STABLE[0], PRESS[0], LED[0] remain 0 throughout.
- Toggle, MODE=2'b01: three clean presses/releases on ch0 → LED[0] 1, 0, 1 after each PRESS; RELEASE does not change LED[0]; switching MODE[0] to 0 shows LED[0]=STABLE[0] same cycle, back to 1 shows LED[0]=1.
- Independent channels: ch0 and ch1 pressed same cycle, ch1 bouncing → PRESS=2'b01 at the expected edge, ch1 PRESS only after 4 clean cycles.
- Reset mid-count: SW[1] high, RST at count 2 → no PRESS; after RST low, PRESS[1] exactly 5 edges after first post-reset sample.
